// File: rtl/branch_predictor_btb.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit counters.
// Table is cleared by a sequential walk after reset or flush.
module branch_predictor_btb #(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = 32 - IDX_W - 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  output logic        ready,
  input  logic [31:0] lookup_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [31:0]      tgt_q   [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             u_hit, u_en;
  logic [1:0]       u_ctr_cur, u_ctr_nxt;
  logic             unused_pc_lsb;

  assign unused_pc_lsb = ^upd_pc[1:0];

  assign ready = (state_q == S_RUN);

  assign l_idx = lookup_pc[IDX_W+1:2];
  assign l_tag = lookup_pc[31:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[31:IDX_W+2];

  assign pred_hit    = ready & valid_q[l_idx] & (tag_q[l_idx] == l_tag);
  assign pred_taken  = pred_hit & ctr_q[l_idx][1];
  assign pred_target = pred_taken ? tgt_q[l_idx] : lookup_pc + 32'd4;

  // flush takes priority: an update in the flush cycle is dropped
  assign u_en  = upd_valid & ready & ~flush;
  assign u_hit = valid_q[u_idx] & (tag_q[u_idx] == u_tag);

  always_comb begin
    u_ctr_cur = ctr_q[u_idx];
    u_ctr_nxt = u_ctr_cur;
    if (upd_taken && u_ctr_cur != 2'b11)
      u_ctr_nxt = u_ctr_cur + 2'd1;
    else if (!upd_taken && u_ctr_cur != 2'b00)
      u_ctr_nxt = u_ctr_cur - 2'd1;
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    unique case (state_q)
      S_INIT: begin
        if (flush) begin
          init_idx_d = '0;
        end else if (init_idx_q == IDX_W'(ENTRIES - 1)) begin
          state_d    = S_RUN;
          init_idx_d = '0;
        end else begin
          init_idx_d = init_idx_q + IDX_W'(1);
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d    = S_INIT;
          init_idx_d = '0;
        end
      end
      default: begin
        state_d    = S_INIT;
        init_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  // Single write port: init walk in INIT, training in RUN
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      valid_q[init_idx_q] <= 1'b0;
      ctr_q[init_idx_q]   <= 2'b01;
    end else if (u_en) begin
      if (u_hit) begin
        ctr_q[u_idx] <= u_ctr_nxt;
        if (upd_taken)
          tgt_q[u_idx] <= upd_target;
      end else if (upd_taken) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        tgt_q[u_idx]   <= upd_target;
        ctr_q[u_idx]   <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed self-checking bench for branch_predictor_btb.
// Each task drives one scenario and compares against hand-computed values.
module tb_branch_predictor_btb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        ready;
  logic [31:0] lookup_pc = '0;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;

  int n_vec = 0;
  int n_err = 0;

  branch_predictor_btb dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .ready       (ready),
    .lookup_pc   (lookup_pc),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk,
                     input logic [31:0] tg);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = tk;
    upd_target = tg;
    tick();
    upd_valid  = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    lookup_pc = pc;
    #1;
  endtask

  task automatic test_reset();
    int cnt;
    rst_n = 1'b0;
    repeat (3) tick();
    look(32'h100);
    n_vec++;
    if (ready !== 1'b0 || pred_hit !== 1'b0 || pred_taken !== 1'b0
        || pred_target !== 32'h104) begin
      n_err++;
      $display("FAIL reset_hold: rdy=%b hit=%b tk=%b tgt=%h want 0 0 0 00000104",
               ready, pred_hit, pred_taken, pred_target);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 200) begin
      if (cnt == 5) begin
        upd_valid  = 1'b1;
        upd_pc     = 32'h100;
        upd_taken  = 1'b1;
        upd_target = 32'h80;
      end
      tick();
      upd_valid = 1'b0;
      cnt++;
      if (cnt == 10) begin
        look(32'h100);
        n_vec++;
        if (pred_hit !== 1'b0 || pred_taken !== 1'b0
            || pred_target !== 32'h104) begin
          n_err++;
          $display("FAIL init_lookup: hit=%b tk=%b tgt=%h want 0 0 00000104",
                   pred_hit, pred_taken, pred_target);
        end
      end
    end
    n_vec++;
    if (cnt != 64) begin
      n_err++;
      $display("FAIL reset_init_len: got %0d cycles want 64", cnt);
    end
    look(32'h100);
    n_vec++;
    if (pred_hit !== 1'b0 || pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      n_err++;
      $display("FAIL post_init_lookup: hit=%b tk=%b tgt=%h want 0 0 00000104",
               pred_hit, pred_taken, pred_target);
    end
    look(32'hFFFF_FFFC);
    n_vec++;
    if (pred_hit !== 1'b0 || pred_target !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_target: hit=%b tgt=%h want 0 00000000",
               pred_hit, pred_target);
    end
  endtask

  task automatic test_allocate();
    upd(32'h200, 1'b0, 32'h999);
    look(32'h200);
    n_vec++;
    if (pred_hit !== 1'b0) begin
      n_err++;
      $display("FAIL nt_no_alloc: hit=%b want 0", pred_hit);
    end
    upd(32'h100, 1'b1, 32'h80);
    look(32'h100);
    n_vec++;
    if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h80) begin
      n_err++;
      $display("FAIL alloc: hit=%b tk=%b tgt=%h want 1 1 00000080",
               pred_hit, pred_taken, pred_target);
    end
  endtask

  task automatic test_saturation();
    repeat (3) upd(32'h100, 1'b1, 32'h80);
    upd(32'h100, 1'b0, 32'h0);
    look(32'h100);
    n_vec++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
      n_err++;
      $display("FAIL sat_hi: tk=%b tgt=%h want 1 00000080",
               pred_taken, pred_target);
    end
    upd(32'h100, 1'b0, 32'h0);
    look(32'h100);
    n_vec++;
    if (pred_hit !== 1'b1 || pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      n_err++;
      $display("FAIL weak_nt: hit=%b tk=%b tgt=%h want 1 0 00000104",
               pred_hit, pred_taken, pred_target);
    end
    repeat (3) upd(32'h100, 1'b0, 32'h0);
    upd(32'h100, 1'b1, 32'h90);
    look(32'h100);
    n_vec++;
    if (pred_hit !== 1'b1 || pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      n_err++;
      $display("FAIL sat_lo: hit=%b tk=%b tgt=%h want 1 0 00000104",
               pred_hit, pred_taken, pred_target);
    end
    upd(32'h100, 1'b1, 32'h94);
    look(32'h100);
    n_vec++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h94) begin
      n_err++;
      $display("FAIL retarget: tk=%b tgt=%h want 1 00000094",
               pred_taken, pred_target);
    end
  endtask

  task automatic test_alias();
    look(32'h200);
    n_vec++;
    if (pred_hit !== 1'b0 || pred_target !== 32'h204) begin
      n_err++;
      $display("FAIL alias_miss: hit=%b tgt=%h want 0 00000204",
               pred_hit, pred_target);
    end
    upd(32'h200, 1'b1, 32'h40);
    look(32'h200);
    n_vec++;
    if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h40) begin
      n_err++;
      $display("FAIL alias_alloc: hit=%b tk=%b tgt=%h want 1 1 00000040",
               pred_hit, pred_taken, pred_target);
    end
    look(32'h100);
    n_vec++;
    if (pred_hit !== 1'b0 || pred_target !== 32'h104) begin
      n_err++;
      $display("FAIL alias_evict: hit=%b tgt=%h want 0 00000104",
               pred_hit, pred_target);
    end
  endtask

  task automatic test_same_cycle();
    upd(32'h100, 1'b1, 32'h80);
    lookup_pc  = 32'h100;
    upd_valid  = 1'b1;
    upd_pc     = 32'h100;
    upd_taken  = 1'b0;
    upd_target = 32'h0;
    #1;
    n_vec++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
      n_err++;
      $display("FAIL same_cycle_old: tk=%b tgt=%h want 1 00000080",
               pred_taken, pred_target);
    end
    tick();
    upd_valid = 1'b0;
    #1;
    n_vec++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      n_err++;
      $display("FAIL same_cycle_new: tk=%b tgt=%h want 0 00000104",
               pred_taken, pred_target);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      upd_valid  = 1'b1;
      upd_pc     = 32'h1000 + 32'(4 * i);
      upd_taken  = 1'b1;
      upd_target = 32'h2000 + 32'(16 * i);
      tick();
    end
    upd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      look(32'h1000 + 32'(4 * i));
      n_vec++;
      if (pred_hit !== 1'b1 || pred_target !== 32'h2000 + 32'(16 * i)) begin
        n_err++;
        $display("FAIL b2b[%0d]: hit=%b tgt=%h want 1 %h", i, pred_hit,
                 pred_target, 32'h2000 + 32'(16 * i));
      end
    end
  endtask

  task automatic test_flush();
    int cnt;
    upd(32'h104, 1'b1, 32'h500);
    upd(32'h10C, 1'b1, 32'h600);
    look(32'h10C);
    n_vec++;
    if (pred_hit !== 1'b1 || pred_target !== 32'h600) begin
      n_err++;
      $display("FAIL pre_flush: hit=%b tgt=%h want 1 00000600",
               pred_hit, pred_target);
    end
    flush      = 1'b1;
    upd_valid  = 1'b1;
    upd_pc     = 32'h108;
    upd_taken  = 1'b1;
    upd_target = 32'h700;
    tick();
    flush     = 1'b0;
    upd_valid = 1'b0;
    n_vec++;
    if (ready !== 1'b0) begin
      n_err++;
      $display("FAIL flush_ready: got %b want 0", ready);
    end
    cnt = 0;
    while (ready !== 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
    n_vec++;
    if (cnt != 64) begin
      n_err++;
      $display("FAIL flush_init_len: got %0d cycles want 64", cnt);
    end
    for (int i = 0; i < 4; i++) begin
      look(32'h100 + 32'(4 * i));
      n_vec++;
      if (pred_hit !== 1'b0 || pred_taken !== 1'b0) begin
        n_err++;
        $display("FAIL post_flush[%0d]: hit=%b tk=%b want 0 0", i,
                 pred_hit, pred_taken);
      end
    end
    look(32'h1000);
    n_vec++;
    if (pred_hit !== 1'b0) begin
      n_err++;
      $display("FAIL post_flush_b2b: hit=%b want 0", pred_hit);
    end
  endtask

  task automatic test_restart();
    int cnt;
    upd(32'h100, 1'b1, 32'h80);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (30) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
    n_vec++;
    if (cnt != 64) begin
      n_err++;
      $display("FAIL flush_restart_len: got %0d cycles want 64", cnt);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (20) tick();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    n_vec++;
    if (ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_async: ready=%b want 0", ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
    n_vec++;
    if (cnt != 64) begin
      n_err++;
      $display("FAIL rst_restart_len: got %0d cycles want 64", cnt);
    end
    look(32'h100);
    n_vec++;
    if (pred_hit !== 1'b0) begin
      n_err++;
      $display("FAIL post_restart: hit=%b want 0", pred_hit);
    end
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_saturation();
    test_alias();
    test_same_cycle();
    test_back_to_back();
    test_flush();
    test_restart();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Fetch-side branch predictor: a direct-mapped branch target buffer plus a 2-bit saturating-counter history table.
- Predicts taken/not-taken and the target for the current fetch PC.
- Trained by resolved branch outcomes from execute, i.e. the taken result of the branch condition evaluation and the computed target.
- Consumer end of the branch-outcome interface; needed for the pipelined RV32I core.

Parameters:
ENTRIES, 64, number of table entries; power of two, >= 2
IDX_W, 6, log2(ENTRIES); index = pc[IDX_W+1:2]
TAG_W, 24, 32-IDX_W-2; tag = pc[31:IDX_W+2]

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous request to re-initialise all entries
ready  output  1  high when the table is initialised and accepting updates
lookup_pc  input  32  fetch PC to predict
pred_hit  output  1  valid entry with matching tag at lookup_pc
pred_taken  output  1  predicted taken
pred_target  output  32  predicted next PC
upd_valid  input  1  resolved branch present this cycle
upd_pc  input  32  PC of resolved branch
upd_taken  input  1  resolved outcome from execute
upd_target  input  32  resolved branch target

Behaviour:
- Storage per entry: valid bit, TAG_W tag, 32-bit target, 2-bit counter. 00 = strong NT, 01 = weak NT, 10 = weak T, 11 = strong T.
- Reset state: rst_n low asynchronously forces FSM to INIT, init_idx = 0, ready = 0. Array contents are not reset directly; the INIT walk clears them.

FSM:
- INIT: each clock, valid[init_idx] = 0 and ctr[init_idx] = 01, then init_idx++.
  - After the entry ENTRIES-1 write: go to RUN, ready = 1.
  - INIT lasts exactly ENTRIES cycles after rst_n deasserts.
- RUN: ready = 1.
  - flush = 1 at a clock edge: go to INIT, init_idx = 0, ready = 0 on the next cycle.
- flush while in INIT: restarts init_idx at 0.

Lookup (combinational from array state, zero latency):
- pred_hit = ready & valid[idx] & (tag[idx] == lookup_pc tag).
- pred_taken = pred_hit & ctr[idx][1].
- pred_target = upd-independent: when pred_taken, target[idx]; otherwise lookup_pc + 4, wrapping modulo 2^32.
- When ready = 0: pred_hit = 0, pred_taken = 0, pred_target = lookup_pc + 4.

Update (registered, applied at the clock edge when upd_valid & ready; ignored otherwise):
- Hit (valid and tag match at upd_pc index):
  - Counter saturating: +1 if upd_taken (11 stays 11), -1 if not (00 stays 00).
  - If upd_taken, target overwritten with upd_target.
- Miss and upd_taken: allocate. valid = 1, tag = upd_pc tag, target = upd_target, ctr = 10. Replaces any existing entry at that index.
- Miss and not taken: no state change (no allocation of not-taken branches).

Other rules:
- Same-cycle lookup and update to the same index: lookup returns the pre-update value. The update is visible from the next cycle.
- flush and upd_valid in the same cycle: flush wins; the update is dropped.
- Single write port only; no bypass.
- upd_pc[1:0] and lookup_pc[1:0] are ignored.

Test Plan:
- Reset release, ENTRIES=64: ready = 0 for exactly 64 cycles, then 1. Lookup 0x0000_0100 during and after init gives hit = 0, taken = 0, target = 0x0000_0104.
- Allocate: update pc = 0x100, taken = 1, target = 0x80. Next cycle lookup 0x100 gives hit = 1, taken = 1 (ctr = 10), target = 0x80. A prior not-taken update at 0x200 on a miss leaves lookup 0x200 hit = 0.
- Saturation: after allocation at 0x100, 3 taken updates give ctr = 11. Then 2 not-taken updates give ctr = 01, so lookup taken = 0, target = 0x104. 2 more not-taken give ctr = 00; a third not-taken stays 00.
- Aliasing/tag: allocate 0x100, then lookup 0x100 + (64 << 2) = 0x200 (same index, different tag) gives hit = 0. Taken update at 0x200, target 0x40, replaces the entry; lookup 0x100 then gives hit = 0.
- Same-cycle lookup/update at 0x100 (ctr 10, not-taken update): lookup that cycle taken = 1; next cycle taken = 0.
- Flush with populated table and simultaneous upd_valid: ready drops next cycle for 64 cycles, the update is discarded, and all lookups miss afterward. rst_n asserted mid-INIT restarts the 64-cycle count.
